// File: rtl/ex_muldiv_seq.sv
// Sequential multiply/divide/accumulate unit owning the HI/LO pair.
// One operation at a time; arithmetic ops take a fixed WIDTH+2 cycles to Done.
module ex_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             Start,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic [WIDTH-1:0] Out,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic             C,
  output logic             Z,
  output logic             O,
  output logic             N,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;
  localparam logic [3:0] OP_MFHI  = 4'd11;
  localparam logic [3:0] OP_MFLO  = 4'd12;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] hi, lo;
  logic [3:0]       cur_op;
  logic [CW-1:0]    cnt;
  logic             neg_prod, neg_quot, neg_rem, div_zero_case, div_ovf_case;
  logic [WIDTH-1:0] a_orig;
  logic [W2-1:0]    prod, mcand;
  logic [WIDTH-1:0] mplier, rem, quot, dvsr;

  logic             op_arith, op_valid, op_signed, accept, accept_arith;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;

  logic [W2-1:0]    prod_fin, acc, res;
  logic [W2:0]      acc_sum, acc_dif;
  logic [WIDTH-1:0] q_fin, r_fin;
  logic             is_div, f_c, f_z, f_o, f_n, f_dz;

  // Opcode decode, acceptance, back-pressure and MF* read port
  always_comb begin
    op_arith     = (Op >= OP_MULT) && (Op <= OP_MSUBU);
    op_valid     = (Op >= OP_MULT) && (Op <= OP_MFLO);
    op_signed    = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
    accept       = Start && op_valid && !Busy && !Flush;
    accept_arith = accept && op_arith;
    a_neg        = op_signed && A[WIDTH-1];
    b_neg        = op_signed && B[WIDTH-1];
    a_mag        = a_neg ? -A : A;
    b_mag        = b_neg ? -B : B;
    Stall        = Start && op_valid && Busy;
    if (accept && (Op == OP_MFHI)) begin
      Out = hi;
    end else if (accept && (Op == OP_MFLO)) begin
      Out = lo;
    end else begin
      Out = {WIDTH{1'b0}};
    end
  end

  // One restoring-division step on the magnitude registers
  always_comb begin
    div_shift = {rem, quot[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, dvsr};
    div_sub   = div_shift[WIDTH-1:0] - dvsr;
  end

  // Result and flag formation applied at the end of FINISH
  always_comb begin
    prod_fin = neg_prod ? -prod : prod;
    acc      = {hi, lo};
    acc_sum  = {1'b0, acc} + {1'b0, prod_fin};
    acc_dif  = {1'b0, acc} - {1'b0, prod_fin};
    q_fin    = neg_quot ? -quot : quot;
    r_fin    = neg_rem ? -rem : rem;
    is_div   = (cur_op == OP_DIV) || (cur_op == OP_DIVU);
    res      = acc;
    f_c      = 1'b0;
    f_o      = 1'b0;
    f_dz     = 1'b0;
    case (cur_op)
      OP_MULT: begin
        res = prod_fin;
        f_o = prod_fin[W2-1:WIDTH] != {WIDTH{prod_fin[WIDTH-1]}};
      end
      OP_MULTU: begin
        res = prod_fin;
        f_o = |prod_fin[W2-1:WIDTH];
      end
      OP_MADD: begin
        res = acc_sum[W2-1:0];
        f_o = (acc[W2-1] == prod_fin[W2-1]) && (acc_sum[W2-1] != acc[W2-1]);
      end
      OP_MADDU: begin
        res = acc_sum[W2-1:0];
        f_c = acc_sum[W2];
      end
      OP_MSUB: begin
        res = acc_dif[W2-1:0];
        f_o = (acc[W2-1] != prod_fin[W2-1]) && (acc_dif[W2-1] != acc[W2-1]);
      end
      OP_MSUBU: begin
        res = acc_dif[W2-1:0];
        f_c = acc_dif[W2];
      end
      OP_DIV, OP_DIVU: begin
        if (div_zero_case) begin
          res  = {a_orig, {WIDTH{1'b1}}};
          f_dz = 1'b1;
        end else if (div_ovf_case) begin
          res = {{WIDTH{1'b0}}, MOST_NEG};
          f_o = 1'b1;
        end else begin
          res = {r_fin, q_fin};
        end
      end
      default: begin
        res = acc;
      end
    endcase
    // Divide flags look at the quotient only; mult/acc at the full pair
    if (is_div) begin
      f_n = res[WIDTH-1];
      f_z = ~|res[WIDTH-1:0];
    end else begin
      f_n = res[W2-1];
      f_z = ~|res;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept_arith) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (Flush) begin
          state_next = IDLE;
        end else if (cnt == CNT_ZERO) begin
          state_next = FINISH;
        end else begin
          state_next = RUN;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and registered busy indication
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
      Busy  <= 1'b0;
    end else begin
      state <= state_next;
      Busy  <= (state_next != IDLE);
    end
  end

  // Operand capture, shift-add / restoring iteration, HI/LO and flag commit
  always_ff @(posedge clk) begin
    if (!nrst) begin
      hi            <= {WIDTH{1'b0}};
      lo            <= {WIDTH{1'b0}};
      C             <= 1'b0;
      Z             <= 1'b0;
      O             <= 1'b0;
      N             <= 1'b0;
      DivZero       <= 1'b0;
      Done          <= 1'b0;
      cnt           <= CNT_ZERO;
      cur_op        <= 4'd0;
      neg_prod      <= 1'b0;
      neg_quot      <= 1'b0;
      neg_rem       <= 1'b0;
      div_zero_case <= 1'b0;
      div_ovf_case  <= 1'b0;
      a_orig        <= {WIDTH{1'b0}};
      prod          <= {W2{1'b0}};
      mcand         <= {W2{1'b0}};
      mplier        <= {WIDTH{1'b0}};
      rem           <= {WIDTH{1'b0}};
      quot          <= {WIDTH{1'b0}};
      dvsr          <= {WIDTH{1'b0}};
    end else begin
      Done    <= 1'b0;
      DivZero <= 1'b0;
      if (accept_arith) begin
        cur_op        <= Op;
        cnt           <= CNT_LAST;
        neg_prod      <= a_neg ^ b_neg;
        neg_quot      <= a_neg ^ b_neg;
        neg_rem       <= a_neg;
        div_zero_case <= (B == {WIDTH{1'b0}});
        div_ovf_case  <= (Op == OP_DIV) && (A == MOST_NEG) && (B == {WIDTH{1'b1}});
        a_orig        <= A;
        prod          <= {W2{1'b0}};
        mcand         <= {{WIDTH{1'b0}}, a_mag};
        mplier        <= b_mag;
        rem           <= {WIDTH{1'b0}};
        quot          <= a_mag;
        dvsr          <= b_mag;
      end else if (state == RUN) begin
        if (mplier[0]) begin
          prod <= prod + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        if (div_ge) begin
          rem  <= div_sub;
          quot <= {quot[WIDTH-2:0], 1'b1};
        end else begin
          rem  <= div_shift[WIDTH-1:0];
          quot <= {quot[WIDTH-2:0], 1'b0};
        end
        if (cnt != CNT_ZERO) begin
          cnt <= cnt - CW'(1);
        end
      end else if ((state == FINISH) && !Flush) begin
        hi      <= res[W2-1:WIDTH];
        lo      <= res[WIDTH-1:0];
        C       <= f_c;
        Z       <= f_z;
        O       <= f_o;
        N       <= f_n;
        DivZero <= f_dz;
        Done    <= 1'b1;
      end
      if (accept && (Op == OP_MTHI)) begin
        hi <= A;
      end
      if (accept && (Op == OP_MTLO)) begin
        lo <= A;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Scoreboard bench for ex_muldiv_seq: stimulus pushes expected completions and
// MF* reads into queues; a negedge monitor pops and compares.
module tb_ex_muldiv_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         Start = 1'b0;
  logic [3:0]   Op = 4'd0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Flush = 1'b0;
  logic [W-1:0] Out;
  logic         Busy, Stall, Done, C, Z, O, N, DivZero;

  ex_muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .nrst(nrst), .Start(Start), .Op(Op), .A(A), .B(B), .Flush(Flush),
    .Out(Out), .Busy(Busy), .Stall(Stall), .Done(Done),
    .C(C), .Z(Z), .O(O), .N(N), .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // fl = {C, Z, O, N, DivZero}; cyc = cycle number in which Done must appear
  typedef struct { string name; logic [4:0] fl; int cyc; } flag_t;
  typedef struct { string name; logic [W-1:0] out; logic stall; } out_t;
  flag_t fq[$];
  out_t  oq[$];
  flag_t mon_f;
  out_t  mon_o;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: completions against the flag queue, MF* reads against the read queue
  always @(negedge clk) begin
    if (Done) begin
      check("done_expected", {63'd0, fq.size() != 0}, 64'd1);
      if (fq.size() != 0) begin
        mon_f = fq.pop_front();
        check({mon_f.name, "_done_cycle"}, cyc, mon_f.cyc);
        check({mon_f.name, "_flags"}, {C, Z, O, N, DivZero}, mon_f.fl);
      end
    end else begin
      check("divzero_only_with_done", DivZero, 1'b0);
    end
    if (Start && !Flush && (Op == 4'd11 || Op == 4'd12)) begin
      check("mf_expected", {63'd0, oq.size() != 0}, 64'd1);
      if (oq.size() != 0) begin
        mon_o = oq.pop_front();
        check({mon_o.name, "_out"}, Out, mon_o.out);
        check({mon_o.name, "_stall"}, Stall, mon_o.stall);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge clk); #1;
    Start = 1'b0; Op = 4'd0; A = '0; B = '0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      seen = Done;
    end
    if (!seen) check({name, "_done_timeout"}, Done, 1'b1);
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [4:0] fl);
    flag_t e;
    e.name = name; e.fl = fl; e.cyc = cyc + W + 2;
    fq.push_back(e);
    issue(op, a, b);
    wait_done(name);
  endtask

  task automatic read_hilo(input string name, input logic [W-1:0] hi, input logic [W-1:0] lo);
    out_t e;
    e.name = {name, "_hi"}; e.out = hi; e.stall = 1'b0; oq.push_back(e);
    e.name = {name, "_lo"}; e.out = lo; oq.push_back(e);
    issue(4'd11, '0, '0);
    issue(4'd12, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t e;
    flag_t f;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    check("reset_busy", Busy, 1'b0);
    check("reset_done", Done, 1'b0);
    check("reset_stall", Stall, 1'b0);
    check("reset_out", Out, '0);
    check("reset_flags", {C, Z, O, N, DivZero}, 5'b00000);
    read_hilo("reset", 32'h0, 32'h0);

    run_op("mult", 4'd1, 32'hFFFFFFFE, 32'd3, 5'b00010);
    read_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", 4'd2, 32'hFFFFFFFE, 32'd3, 5'b00100);
    read_hilo("multu", 32'h00000002, 32'hFFFFFFFA);
    run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 5'b00010);
    read_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_zero", 4'd4, 32'd5, 32'd0, 5'b00011);
    read_hilo("divu_zero", 32'd5, 32'hFFFFFFFF);
    run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 5'b00110);
    read_hilo("div_ovf", 32'h0, 32'h80000000);

    issue(4'd9, 32'hFFFFFFFF, '0);
    issue(4'd10, 32'hFFFFFFFF, '0);
    run_op("maddu", 4'd6, 32'd1, 32'd1, 5'b11000);
    read_hilo("maddu", 32'h0, 32'h0);
    run_op("msubu", 4'd8, 32'd1, 32'd1, 5'b10010);
    read_hilo("msubu", 32'hFFFFFFFF, 32'hFFFFFFFF);

    // Flush in RUN cycle 10: nothing may complete or change
    issue(4'd1, 32'd7, 32'd9);
    repeat (9) begin @(posedge clk); #1; end
    Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    check("flush_busy", Busy, 1'b0);
    repeat (45) begin @(posedge clk); #1; end
    check("flush_flags_kept", {C, Z, O, N}, 4'b1001);
    read_hilo("flush", 32'hFFFFFFFF, 32'hFFFFFFFF);

    // MFLO held behind a MULTU: stalled W+1 cycles, accepted in the Done cycle
    f.name = "multu_b2b"; f.fl = 5'b00000; f.cyc = cyc + W + 2;
    fq.push_back(f);
    issue(4'd2, 32'd7, 32'd9);
    e.name = "stall_wait"; e.out = '0; e.stall = 1'b1;
    repeat (W + 1) oq.push_back(e);
    e.name = "b2b_mflo"; e.out = 32'h3F; e.stall = 1'b0;
    oq.push_back(e);
    Start = 1'b1; Op = 4'd12;
    repeat (W + 2) begin @(posedge clk); #1; end
    Start = 1'b0; Op = 4'd0;
    read_hilo("multu_b2b", 32'h0, 32'h3F);

    run_op("msub", 4'd7, 32'd2, 32'hFFFFFFFD, 5'b00000);
    read_hilo("msub", 32'h0, 32'h45);

    // Reset in the middle of a divide
    issue(4'd3, 32'd100, 32'd7);
    repeat (5) begin @(posedge clk); #1; end
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    check("midreset_busy", Busy, 1'b0);
    repeat (45) begin @(posedge clk); #1; end
    check("midreset_flags", {C, Z, O, N, DivZero}, 5'b00000);
    read_hilo("midreset", 32'h0, 32'h0);

    repeat (3) begin @(posedge clk); #1; end
    check("queues_drained", fq.size() + oq.size(), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_seq.md
# ex_muldiv_seq

Sequential multiply/divide/accumulate unit for the execute stage, parametrised in datapath width. It owns the HI/LO accumulator pair and executes one HI/LO operation at a time over a fixed WIDTH+2 cycle latency. While an operation is in flight it back-pressures the pipeline through `Stall`. The execute-stage result/flag mux consumes its output, and it supersedes the single-cycle MUL/ACC path.

## Interface
- `WIDTH`, default 32: operand, HI and LO width; must be ≥ 4 and even.
- `clk`  in  1  clock; all state changes on the rising edge.
- `nrst`  in  1  reset, synchronous, active-low.
- `Start`  in  1  `Op` / `A` / `B` are valid this cycle.
- `Op`  in  4  opcode:
  - 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU
  - 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU
  - 9 MTHI, 10 MTLO, 11 MFHI, 12 MFLO
  - 13–15 behave as NOP.
- `A`  in  WIDTH  rs operand (dividend / multiplicand / MT* source).
- `B`  in  WIDTH  rt operand (divisor / multiplier).
- `Flush`  in  1  abort any in-flight operation.
- `Out`  out  WIDTH  MF* read data; combinational; 0 otherwise.
- `Busy`  out  1  operation in flight (registered).
- `Stall`  out  1  a Start was refused this cycle (combinational).
- `Done`  out  1  one-cycle pulse; new HI/LO and flags are visible.
- `C`, `Z`, `O`, `N`  out  1 each  registered result flags.
- `DivZero`  out  1  divide-by-zero indication, high only with `Done`.

## Operation
- **Reset:** `nrst`=0 at an edge clears:
  - state to IDLE, HI, LO, C, Z, O, N, DivZero, Done, Busy and the iteration counter.
  - `Out` and `Stall` are 0 while `Start`=0.
- **States:**
  - IDLE → RUN on an accepted arithmetic op (1–8).
  - RUN lasts exactly WIDTH cycles (counter WIDTH-1 down to 0), then → FINISH.
  - FINISH lasts 1 cycle, then → IDLE, with `Done`=1 in that IDLE cycle.
- **Acceptance:** `Start`=1 with a non-NOP op is accepted only when `Busy`=0 and `Flush`=0.
  - If `Start`=1, `Busy`=1 and the op is non-NOP, then `Stall`=1 and the op is ignored. The pipeline must hold and re-present it.
- **MTHI / MTLO:** single cycle, no `Busy`. HI or LO ← `A` at the accepting edge. Flags are unchanged.
- **MFHI / MFLO:** `Out` = HI or LO combinationally in the accepting cycle. No state change.
- **Multiply:**
  - Shift-add over operand magnitudes, producing a 2·WIDTH product. Signed ops negate the product in FINISH when the signs differ.
  - MADD*/MSUB*: {HI,LO} ± product, computed modulo 2^(2·WIDTH) in FINISH.
- **Divide:**
  - Restoring division over magnitudes. The quotient truncates toward zero; the remainder takes the dividend's sign.
  - LO ← quotient, HI ← remainder.
- **Divide by zero:** LO ← all ones, HI ← `A`, and `DivZero`=1 with `Done`. RUN/FINISH latency is still observed.
- **Signed divide overflow** (most-negative / −1): LO ← most-negative, HI ← 0, O=1.
- **Flags** are written at the end of FINISH and held until the next completion:
  - N: MSB of the new {HI,LO} (mult/acc) or of the quotient (div).
  - Z: new {HI,LO}==0 (mult/acc) or quotient==0 (div).
  - O for MULT: HI ≠ sign-extension of LO. For MULTU: HI≠0. For signed MADD/MSUB: 2·WIDTH signed overflow. For div: the overflow case only.
  - C: carry out of MADDU, or borrow of MSUBU; 0 for all other ops.
- **Flush:** highest priority.
  - In RUN or FINISH: state → IDLE at the next edge, `Busy`=0. HI, LO and flags are unchanged, and no `Done` is produced.
  - In IDLE: `Start` is ignored and `Stall`=0.

## Timing
- Op accepted at edge k:
  - `Busy`=1 in cycles k+1 … k+WIDTH+1.
  - FINISH is cycle k+WIDTH+1.
  - In cycle k+WIDTH+2: `Done`=1, `Busy`=0, and new HI/LO/flags are visible.
- The fixed latency from acceptance to `Done` is WIDTH+2 cycles, independent of operand values.
- Back-to-back: a Start presented in the `Done` cycle is accepted, including MF*, which returns the new value.
- `Stall` is combinational from `Start`, `Op` and `Busy`. The registered `Busy` guarantees there is no combinational loop.
- Reset asserted mid-RUN wins over everything: the state is cleared at that edge and no `Done` is produced.

## Test plan
- **Reset and idle read:** hold `nrst`=0 for 2 cycles, then release; MFHI, then MFLO → `Out`=0; all flags, `Busy`, `Done` and `Stall` are 0.
- **Signed and unsigned multiply:**
  - MULT A=0xFFFFFFFE, B=3 → `Done` exactly 34 cycles after acceptance; HI=0xFFFFFFFF, LO=0xFFFFFFFA, N=1, O=0.
  - MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA, O=1.
- **Divide:**
  - DIV A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU A=5, B=0 → LO=0xFFFFFFFF, HI=5, `DivZero`=1 for one cycle.
- **Accumulate wrap:** MTHI 0xFFFFFFFF, MTLO 0xFFFFFFFF, then MADDU A=1, B=1 → HI=LO=0, C=1, Z=1. Then MSUBU A=1, B=1 → HI=LO=0xFFFFFFFF, C=1.
- **Stall and back-to-back:** MULTU 7×9 accepted, then MFLO held on `Start` → `Stall`=1 every cycle until `Done`. In the `Done` cycle `Stall`=0 and `Out`=0x3F.
- **Flush and reset mid-operation:**
  - Flush at RUN cycle 10 → `Busy`=0 next cycle, no `Done`, HI/LO keep their prior values.
  - `nrst`=0 during a DIV → HI=LO=0 and no `Done`.
